approx_mul_nibble_seq: RTL and testbench
========================================

Name: approx_mul_nibble_seq

Overview:
- Sequencer that shares one 8x4 unsigned partial-product array between the two nibbles of the x operand, producing an 8x8 unsigned product.
- Per transaction it runs either exact mode (two passes: low nibble, then high nibble) or approximate l=4 mode (high-nibble pass plus fixed low-nibble compensation bits).
- It sits between an operand source and a result sink, both using valid/ready handshakes.
- It lets the datapath trade accuracy for one cycle of latency per operation.

Parameters:
- COMP_EN, 1: approximate mode adds the compensation terms when 1; 0 = pure truncation of the low nibble.
- CNT_W, 16: width of the completed-transaction counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- in_x  input  8  multiplier operand x
- in_y  input  8  multiplicand y
- in_approx  input  1  1 = approximate mode, 0 = exact
- out_valid  output  1  result valid
- out_ready  input  1  sink accepts result
- out_z  output  16  product
- out_approx  output  1  mode the result was computed in
- busy  output  1  FSM not IDLE
- done_cnt  output  CNT_W  completed transactions, wraps

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: FSM=IDLE, out_valid=0, out_z=0, out_approx=0, busy=0, done_cnt=0, internal accumulator and operand registers=0. in_ready=1 once reset is released.
- Reset asserted mid-operation aborts the transaction immediately. The result is never presented.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, register x, y and mode. Next state is LO if mode is exact, HI if mode is approximate.
  - LO: acc <= y*x[3:0] (12-bit result, zero-extended). Next state HI.
  - HI: acc <= acc + (y*x[7:4] << 4), plus comp when in approximate mode and COMP_EN=1. In approximate mode acc is first treated as 0. Next state DONE.
  - DONE: out_valid=1, out_z=acc, out_approx=registered mode. Hold until out_ready.
- DONE handshake: on out_valid&out_ready, done_cnt increments (wraps at 2^CNT_W).
  - If in_valid is also high, in_ready=1 in DONE and the new operands are accepted on the same edge (go to LO or HI).
  - Otherwise go to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). in_ready is low in LO and HI.
- Latency, counted from the accept edge to the first cycle out_valid is high: exact = 2 edges, approximate = 1 edge. Back-to-back throughput is one result per 3 cycles (exact) or 2 cycles (approximate).
- Only one 8x4 multiply is performed per cycle. The LO and HI passes use the same array, with the nibble selected by state.
- Compensation comp (16-bit, all other bits 0), with x_i/y_j denoting the registered operand bits:
  - bit8 = (x0&y7)|(x1&y6)
  - bit9, term 1 = (x2&y6)|(x3&y5)
  - bit10, term 1 = x2&y7&x3&y6
  - bit9, term 2 = (x2&y7)|(x3&y6)
  - bit10, term 2 = x3&y7
  - comp = sum of the two 11-bit vectors (term1 vector = bits 8–10 of term 1, term2 vector = bits 9–10 of term 2).
- Arithmetic is modulo 2^16. The approximate maximum is 0xFC10, so it never overflows.
- out_z, out_approx and out_valid are stable while out_valid=1 and out_ready=0. Input changes during LO/HI/DONE are ignored.
- busy=1 in LO, HI and DONE.

Test Plan:
- Exact mode, x=0xFF, y=0xFF, out_ready=1 → out_valid 2 edges after accept, out_z=0xFE01, out_approx=0, done_cnt=1.
- Approximate mode, x=0xFF, y=0xFF, COMP_EN=1 → out_valid 1 edge after accept, out_z=0xFC10. Approximate mode, x=0x0F, y=0xFF → out_z=0x0D00; same operands with COMP_EN=0 → 0x0000; exact mode → 0x0EF1.
- x=0x12, y=0x34: exact → 0x03A8; approximate → 0x0340 (all comp terms zero).
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 → out_z stable, in_ready=0, no second accept. Then raise out_ready → result consumed and next operands accepted on the same edge.
- Back-to-back: 4 alternating exact/approximate transactions with out_ready=1 → correct out_approx tags, results in order, done_cnt=4. With CNT_W=2, a 5th transaction wraps done_cnt to 1.
- Assert rst_n=0 during LO of an exact op → out_valid=0 and busy=0 immediately, done_cnt=0. After release, a new transaction completes normally.

Source files
------------

// File: rtl/approx_mul_nibble_seq.sv
// 8x8 unsigned multiplier built from one shared 8x4 partial-product array, run in two passes
// (exact) or one high-nibble pass plus fixed low-nibble compensation (approximate).
module approx_mul_nibble_seq #(
  parameter bit          COMP_EN = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_x,
  input  logic [7:0]       in_y,
  input  logic             in_approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_z,
  output logic             out_approx,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e             state_q, state_d;
  logic [7:0]         x_q, x_d;
  logic [7:0]         y_q, y_d;
  logic               approx_q, approx_d;
  logic [15:0]        acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic [3:0]         nib;
  logic [11:0]        pp;
  logic [10:0]        term1, term2;
  logic [15:0]        comp;

  assign in_ready = (state_q == StIdle) | ((state_q == StDone) & out_ready);
  assign accept   = in_valid & in_ready;

  // Single 8x4 array; the nibble of x is picked by the current pass.
  assign nib = (state_q == StLo) ? x_q[3:0] : x_q[7:4];
  assign pp  = {4'b0000, y_q} * {8'h00, nib};

  // Low-nibble compensation bits standing in for the skipped LO pass.
  assign term1 = {x_q[2] & y_q[7] & x_q[3] & y_q[6],
                  (x_q[2] & y_q[6]) | (x_q[3] & y_q[5]),
                  (x_q[0] & y_q[7]) | (x_q[1] & y_q[6]),
                  8'h00};
  assign term2 = {x_q[3] & y_q[7],
                  (x_q[2] & y_q[7]) | (x_q[3] & y_q[6]),
                  9'h000};
  assign comp  = COMP_EN ? ({5'b00000, term1} + {5'b00000, term2}) : 16'h0000;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    approx_d = approx_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: ;
      StLo: begin
        acc_d   = {4'b0000, pp};
        state_d = StHi;
      end
      StHi: begin
        acc_d   = (approx_q ? 16'h0000 : acc_q) + {pp, 4'b0000} + (approx_q ? comp : 16'h0000);
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Accept is only possible in IDLE or while the DONE result is being consumed.
    if (accept) begin
      x_d      = in_x;
      y_d      = in_y;
      approx_d = in_approx;
      state_d  = in_approx ? StHi : StLo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      x_q      <= 8'h00;
      y_q      <= 8'h00;
      approx_q <= 1'b0;
      acc_q    <= 16'h0000;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      approx_q <= approx_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid  = (state_q == StDone);
  assign out_z      = out_valid ? acc_q : 16'h0000;
  assign out_approx = out_valid & approx_q;
  assign busy       = (state_q != StIdle);
  assign done_cnt   = cnt_q;

endmodule

// File: tb/tb_approx_mul_nibble_seq.sv
// Bench for approx_mul_nibble_seq: a COMP_EN=1/CNT_W=16 instance and a COMP_EN=0/CNT_W=2
// instance share all inputs; a queue of expected results is checked as outputs appear.
module tb_approx_mul_nibble_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_approx = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_x = 8'h00, in_y = 8'h00;

  logic        in_ready, out_valid, out_approx, busy;
  logic [15:0] out_z, done_cnt;
  logic        b_in_ready, b_out_valid, b_out_approx, b_busy;
  logic [15:0] b_out_z;
  logic [1:0]  b_done_cnt;

  typedef struct packed {
    logic [15:0] z;
    logic [15:0] z_nc;
    logic        a;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] cnt_exp = 16'h0000;

  always #5 clk = ~clk;

  approx_mul_nibble_seq #(.COMP_EN(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .in_y(in_y), .in_approx(in_approx), .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_approx(out_approx), .busy(busy), .done_cnt(done_cnt)
  );

  approx_mul_nibble_seq #(.COMP_EN(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .in_x(in_x),
    .in_y(in_y), .in_approx(in_approx), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_z(b_out_z), .out_approx(b_out_approx), .busy(b_busy), .done_cnt(b_done_cnt)
  );

  function automatic logic [15:0] approx_model(input logic [7:0] x, input logic [7:0] y,
                                               input bit comp_en);
    logic [10:0] t1, t2;
    logic [15:0] r;
    r  = (16'(y) * 16'(x[7:4])) << 4;
    t1 = {x[2] & y[7] & x[3] & y[6], (x[2] & y[6]) | (x[3] & y[5]),
          (x[0] & y[7]) | (x[1] & y[6]), 8'h00};
    t2 = {x[3] & y[7], (x[2] & y[7]) | (x[3] & y[6]), 9'h000};
    if (comp_en) r = r + 16'(t1) + 16'(t2);
    return r;
  endfunction

  task automatic test_reset();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst out_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst busy: got %b want 0", busy); end
    total++; if (out_z !== 16'h0) begin bad++; $display("FAIL rst out_z: got %h want 0000", out_z); end
    total++; if (done_cnt !== 16'h0) begin bad++; $display("FAIL rst done_cnt: got %0d want 0", done_cnt); end
    total++; if (out_approx !== 1'b0) begin bad++; $display("FAIL rst out_approx: got %b want 0", out_approx); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single(input string name, input logic [7:0] x, input logic [7:0] y,
                             input logic a, input logic [15:0] ez, input logic [15:0] ez_nc);
    exp_t e;
    int   lat;
    @(posedge clk); #1;
    in_x = x; in_y = y; in_approx = a; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s in_ready: got %b want 1", name, in_ready); end
    @(posedge clk); #1;
    // Scramble inputs after accept; the registered operands must be used.
    in_valid = 1'b0; in_x = ~x; in_y = ~y; in_approx = ~a;
    e.z = ez; e.z_nc = ez_nc; e.a = a;
    sb.push_back(e);
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!out_valid && lat < 8);
    e = sb.pop_front();
    total++; if (lat != (a ? 1 : 2)) begin bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, a ? 1 : 2); end
    total++; if (out_z !== e.z) begin bad++; $display("FAIL %s out_z: got %h want %h", name, out_z, e.z); end
    total++; if (out_approx !== e.a) begin bad++; $display("FAIL %s out_approx: got %b want %b", name, out_approx, e.a); end
    total++; if (b_out_z !== e.z_nc) begin bad++; $display("FAIL %s nocomp out_z: got %h want %h", name, b_out_z, e.z_nc); end
    @(posedge clk); #1;
    cnt_exp++;
    total++; if (done_cnt !== cnt_exp) begin bad++; $display("FAIL %s done_cnt: got %0d want %0d", name, done_cnt, cnt_exp); end
    total++; if (b_done_cnt !== cnt_exp[1:0]) begin bad++; $display("FAIL %s w2 done_cnt: got %0d want %0d", name, b_done_cnt, cnt_exp[1:0]); end
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL %s idle after: busy=%b out_valid=%b want 0 0", name, busy, out_valid); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   n;
    @(posedge clk); #1;
    in_x = 8'hAB; in_y = 8'hCD; in_approx = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    e.z = 16'h88EF; e.z_nc = 16'h88EF; e.a = 1'b0;
    sb.push_back(e);
    in_x = 8'h12; in_y = 8'h34; in_approx = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 8);
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_z !== e.z || in_ready !== 1'b0 || out_approx !== 1'b0) begin
        bad++;
        $display("FAIL bp hold %0d: valid=%b z=%h ready=%b approx=%b want 1 %h 0 0",
                 k, out_valid, out_z, in_ready, out_approx, e.z);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp release in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    cnt_exp++;
    in_valid = 1'b0;
    e.z = 16'h0340; e.z_nc = 16'h0340; e.a = 1'b1;
    sb.push_back(e);
    total++; if (done_cnt !== cnt_exp) begin bad++; $display("FAIL bp done_cnt: got %0d want %0d", done_cnt, cnt_exp); end
    total++; if (busy !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp reaccept: busy=%b valid=%b want 1 0", busy, out_valid); end
    @(negedge clk);
    @(negedge clk);
    e = sb.pop_front();
    total++; if (out_valid !== 1'b1 || out_z !== e.z || out_approx !== 1'b1) begin
      bad++; $display("FAIL bp second: valid=%b z=%h approx=%b want 1 %h 1", out_valid, out_z, out_approx, e.z);
    end
    @(posedge clk); #1;
    cnt_exp++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] xs[5];
    logic [7:0] ys[5];
    logic       as[5];
    exp_t       e;
    int         i, got, cyc, last_acc;
    logic       prev_a;
    bit         acc, cons;
    xs = '{8'hFF, 8'hFF, 8'h0F, 8'h12, 8'hC7};
    ys = '{8'hFF, 8'hFF, 8'hFF, 8'h34, 8'h6B};
    as = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    @(posedge clk); #1;
    rst_n = 1'b0; cnt_exp = 16'h0; sb.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    in_x = xs[0]; in_y = ys[0]; in_approx = as[0]; in_valid = 1'b1; out_ready = 1'b1;
    i = 0; got = 0; cyc = 0; last_acc = 0; prev_a = 1'b0;
    while (got < 5 && cyc < 100) begin
      @(negedge clk); cyc++;
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (cons) begin
        if (sb.size() == 0) begin
          total++; bad++; $display("FAIL b2b unexpected result: z=%h want none", out_z);
        end else begin
          e = sb.pop_front();
          total++; if (out_z !== e.z) begin bad++; $display("FAIL b2b %0d out_z: got %h want %h", got, out_z, e.z); end
          total++; if (out_approx !== e.a) begin bad++; $display("FAIL b2b %0d out_approx: got %b want %b", got, out_approx, e.a); end
          total++; if (b_out_z !== e.z_nc) begin bad++; $display("FAIL b2b %0d nocomp out_z: got %h want %h", got, b_out_z, e.z_nc); end
        end
        got++; cnt_exp++;
      end
      if (acc) begin
        if (i > 0) begin
          total++;
          if (cyc - last_acc != (prev_a ? 2 : 3)) begin
            bad++; $display("FAIL b2b %0d spacing: got %0d want %0d", i, cyc - last_acc, prev_a ? 2 : 3);
          end
        end
        last_acc = cyc; prev_a = as[i];
        e.a    = as[i];
        e.z    = as[i] ? approx_model(xs[i], ys[i], 1'b1) : 16'(xs[i]) * 16'(ys[i]);
        e.z_nc = as[i] ? approx_model(xs[i], ys[i], 1'b0) : 16'(xs[i]) * 16'(ys[i]);
        sb.push_back(e);
        i++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (i < 5) begin in_x = xs[i]; in_y = ys[i]; in_approx = as[i]; end
        else in_valid = 1'b0;
      end
      if (cons) begin
        total++; if (done_cnt !== cnt_exp) begin bad++; $display("FAIL b2b done_cnt: got %0d want %0d", done_cnt, cnt_exp); end
        total++; if (b_done_cnt !== cnt_exp[1:0]) begin bad++; $display("FAIL b2b w2 done_cnt: got %0d want %0d", b_done_cnt, cnt_exp[1:0]); end
      end
    end
    total++; if (got != 5) begin bad++; $display("FAIL b2b timeout: got %0d results want 5", got); end
    total++; if (b_done_cnt !== 2'd1) begin bad++; $display("FAIL b2b wrap: got %0d want 1", b_done_cnt); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(posedge clk); #1;
    in_x = 8'hFF; in_y = 8'hFF; in_approx = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (busy !== 1'b1 || done_cnt !== cnt_exp) begin
      bad++; $display("FAIL rmid pre: busy=%b done_cnt=%0d want 1 %0d", busy, done_cnt, cnt_exp);
    end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || b_busy !== 1'b0) begin
      bad++; $display("FAIL rmid abort: valid=%b busy=%b b_busy=%b want 0 0 0", out_valid, busy, b_busy);
    end
    total++; if (done_cnt !== 16'h0) begin bad++; $display("FAIL rmid done_cnt: got %0d want 0", done_cnt); end
    cnt_exp = 16'h0; sb.delete();
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL rmid stale result: out_valid seen=1 want 0"); end
    test_single("post_rst", 8'h12, 8'h34, 1'b0, 16'h03A8, 16'h03A8);
  endtask

  initial begin
    test_reset();
    test_single("ex_ffff",   8'hFF, 8'hFF, 1'b0, 16'hFE01, 16'hFE01);
    test_single("ap_ffff",   8'hFF, 8'hFF, 1'b1, 16'hFC10, 16'hEF10);
    test_single("ap_0fff",   8'h0F, 8'hFF, 1'b1, 16'h0D00, 16'h0000);
    test_single("ex_0fff",   8'h0F, 8'hFF, 1'b0, 16'h0EF1, 16'h0EF1);
    test_single("ex_1234",   8'h12, 8'h34, 1'b0, 16'h03A8, 16'h03A8);
    test_single("ap_1234",   8'h12, 8'h34, 1'b1, 16'h0340, 16'h0340);
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
